ram_4096_fifo_ctrl: RTL and testbench
=====================================

# ram_4096_fifo_ctrl

Streaming FIFO controller that acts as the initiator of the 4K x 64 dual-port RAM. It accepts words on a valid/ready slave port and writes them into the RAM. It prefetches words back out through the RAM's read port and presents them in order on a valid/ready master port. It sits between a producer and a consumer and instantiates nothing. It drives the RAM's write/read ports and samples the RAM's shared tri-state data bus.

## Interface
- DATA_W, 64, data word width (equals RAM width)
- ADDR_W, 12, RAM address width
- DEPTH, 4096, RAM words (2**ADDR_W)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  producer word valid
- s_ready  out  1  controller can accept a word
- s_data  in  DATA_W  producer word
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accepts word
- m_data  out  DATA_W  output word
- count  out  ADDR_W+1  total occupancy (RAM + in-flight + output buffer), max DEPTH+2
- full  out  1  RAM storage full (s_ready low)
- empty  out  1  count == 0
- ram_data_in  out  DATA_W  to RAM data_in
- ram_wr_address  out  ADDR_W  to RAM wr_address
- ram_rd_address  out  ADDR_W  to RAM rd_address
- ram_write  out  1  to RAM write
- ram_read  out  1  to RAM read
- ram_data_out  in  DATA_W  from RAM tri-state data_out; valid only one cycle after ram_read

## Operation
- State: wr_ptr, rd_ptr (ADDR_W, wrap 4095->0 naturally), ram_cnt (0..DEPTH), inflight (0/1), 2-entry output buffer ob (ob_cnt 0..2).
- Write: s_ready = !rst && ram_cnt < DEPTH. On s_valid && s_ready: ram_write=1, ram_wr_address=wr_ptr, ram_data_in=s_data in the same cycle (combinational), wr_ptr++ at edge. Otherwise ram_write=0, address/data hold last value.
- Read issue: ram_read=1 when ram_cnt>0 and ob_cnt+inflight < 2 and, if inflight, ob_cnt+inflight+1 <= 2 after this cycle's pop. Exact rule: issue iff ram_cnt>0 && (ob_cnt + inflight - pop) < 2. ram_rd_address=rd_ptr; rd_ptr++ and ram_cnt-- at edge; inflight<=1.
- Capture: when inflight=1, ram_data_out is written into ob at the edge. Capture is ignored in all other cycles (bus may be Z/X).
- Pop: m_valid = ob_cnt>0; m_data = ob head; on m_valid && m_ready head advances.
- ram_cnt next = ram_cnt + push - issue; count = ram_cnt + inflight + ob_cnt.
- full = ram_cnt==DEPTH; empty = count==0.
- Simultaneous push/issue: allowed whenever ram_cnt>0. Addresses cannot collide, since rd_ptr==wr_ptr only when ram_cnt is 0 or DEPTH.
- Simultaneous push, issue, capture, pop in one cycle: all take effect; counters update by net delta.
- Order: words emerge on m_data in exact push order, no loss, no duplication.

## Timing
- RAM read contract: read/rd_address sampled at edge E, data_out valid between E and E+1, captured at E+1.
- Reset (rst high at an edge): pointers, ram_cnt, inflight, ob_cnt = 0. After reset: m_valid=0, m_data=0, ram_read=0, ram_write=0, ram addresses=0, ram_data_in=0, count=0, full=0, empty=1. s_ready=0 while rst high, 1 the cycle after.
- Reset mid-operation: any in-flight read is discarded. RAM contents are logically lost. No RAM access is issued during rst.
- Latency, empty FIFO: push at edge E0; ram_read high in cycle after E0; m_valid high after E2 (3 cycles push-to-valid).
- Throughput: 1 word/cycle sustained in both directions once the output buffer is primed. m_ready low never drops data. Holding m_ready high with ob_cnt=2 sustains issue every cycle.
- full asserts the cycle ram_cnt reaches DEPTH. s_ready deasserts the same cycle. Total storage = DEPTH+2.

## Test plan
- Reset, push 0xA5A5_0000_0000_0001 with m_ready=1 -> ram_write with addr 0 that cycle, ram_read addr 0 next cycle, m_valid with same data 3 cycles after push, empty=1 after pop.
- m_ready=0, push 4098 incrementing words -> ob_cnt=2, full=1, s_ready=0, count=4098. Release m_ready -> 4098 words out in order 0..4097.
- Continuous push/pop 10000 words, m_ready=1 -> one word per cycle after priming, pointers wrap 4095->0 twice, data in order.
- Random s_valid/m_ready (50%) over 20000 words -> scoreboard exact order match, count always equals pushes minus pops.
- Assert rst with 100 words stored and a read in flight -> next cycle m_valid=0, count=0, empty=1, ram_read=0. Push 0x1234 -> appears 3 cycles later, not stale data.
- Drive ram_data_out to Z/X in non-capture cycles -> m_data never takes X.

Source files
------------

// File: rtl/ram_4096_fifo_ctrl.sv
// ram_4096_fifo_ctrl
//   Streaming FIFO controller that uses an external 4K x 64 dual-port RAM as
//   storage. Producer words are written into the RAM as they arrive. Words are
//   prefetched back through the RAM read port into a 2-entry output buffer, so
//   the consumer side can run at one word per clock.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   s_valid/s_ready/s_data   producer valid/ready slave port
//   m_valid/m_ready/m_data   consumer valid/ready master port
//   count           words held (RAM + read in flight + output buffer), up to DEPTH+2
//   full            RAM storage full (s_ready is low)
//   empty           count == 0
//   ram_data_in, ram_wr_address, ram_write   RAM write port
//   ram_rd_address, ram_read                 RAM read port
//   ram_data_out    RAM read data, meaningful only the cycle after ram_read
module ram_4096_fifo_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_wr_address,
  output logic [ADDR_W-1:0] ram_rd_address,
  output logic              ram_write,
  output logic              ram_read,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  // Pointers are exactly ADDR_W wide so they wrap 4095 -> 0 on their own.
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_last_wr_addr;
  logic [DATA_W-1:0] r_last_wr_data;
  logic [ADDR_W:0]   r_ram_cnt;
  logic              r_inflight;
  logic [DATA_W-1:0] r_ob [2];
  logic              r_ob_head;
  logic [1:0]        r_ob_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic [1:0]        w_ob_after_pop;
  logic              w_ob_tail;

  // Handshakes. Everything that touches the RAM is gated by rst so no access
  // is issued while the block is being reset.
  assign s_ready = !rst && (r_ram_cnt < DEPTH_C);
  assign w_push  = s_valid && s_ready;
  assign m_valid = (r_ob_cnt != 2'd0);
  assign w_pop   = m_valid && m_ready;

  // Output-buffer occupancy once this cycle's capture and pop have landed.
  // A pop implies ob_cnt >= 1 and ob_cnt + inflight never exceeds 2, so this
  // cannot wrap. A new read is only issued if its word will have a free slot.
  assign w_ob_after_pop = r_ob_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue        = !rst && (r_ram_cnt != '0) && (w_ob_after_pop < 2'd2);

  // While a read is in flight ob_cnt is at most 1, so the free slot is the
  // head slot XOR ob_cnt[0].
  assign w_ob_tail = r_ob_head ^ r_ob_cnt[0];

  // RAM ports: the write address/data are live in the push cycle and
  // otherwise hold their last driven value.
  assign ram_write      = w_push;
  assign ram_wr_address = w_push ? r_wr_ptr : r_last_wr_addr;
  assign ram_data_in    = w_push ? s_data   : r_last_wr_data;
  assign ram_read       = w_issue;
  assign ram_rd_address = r_rd_ptr;

  assign m_data = r_ob[r_ob_head];
  assign count  = r_ram_cnt + (ADDR_W+1)'(r_inflight) + (ADDR_W+1)'(r_ob_cnt);
  assign full   = (r_ram_cnt == DEPTH_C);
  assign empty  = (count == '0);

  // NOTE: state registers use non-blocking assignments so every update below
  // sees the pre-edge value of every other register, whatever the order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_last_wr_addr <= '0;
      r_last_wr_data <= '0;
      r_ram_cnt      <= '0;
      r_inflight     <= 1'b0;
      r_ob_head      <= 1'b0;
      r_ob_cnt       <= 2'd0;
      // NOTE: the two buffer entries are reset (unlike the RAM) because
      // m_data must read 0 after reset and must never expose stale words.
      r_ob[0]        <= '0;
      r_ob[1]        <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr       <= r_wr_ptr + 1'b1;
        r_last_wr_addr <= r_wr_ptr;
        r_last_wr_data <= s_data;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_ram_cnt  <= r_ram_cnt + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_issue);
      r_inflight <= w_issue;
      // The read bus is only sampled in the cycle after a read was issued.
      if (r_inflight) begin
        r_ob[w_ob_tail] <= ram_data_out;
      end
      if (w_pop) begin
        r_ob_head <= ~r_ob_head;
      end
      r_ob_cnt <= w_ob_after_pop;
    end
  end

endmodule

// File: tb/tb_ram_4096_fifo_ctrl.sv
// tb_ram_4096_fifo_ctrl
//   Bench for ram_4096_fifo_ctrl. Contains a behavioural 4K x 64 RAM that
//   returns read data one cycle after ram_read and drives junk on the bus in
//   every other cycle. A reference model (a queue of accepted words plus
//   push/read counters) is checked against the DUT on every falling edge.
module tb_ram_4096_fifo_ctrl;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] ram_data_in;
  logic [ADDR_W-1:0] ram_wr_address;
  logic [ADDR_W-1:0] ram_rd_address;
  logic              ram_write;
  logic              ram_read;
  logic [DATA_W-1:0] ram_data_out;

  always #5 clk = ~clk;

  ram_4096_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .full(full), .empty(empty),
    .ram_data_in(ram_data_in), .ram_wr_address(ram_wr_address),
    .ram_rd_address(ram_rd_address), .ram_write(ram_write),
    .ram_read(ram_read), .ram_data_out(ram_data_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural RAM ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_pend = 1'b0;
  logic [DATA_W-1:0] rd_q = '0;
  logic [DATA_W-1:0] bus_junk = '0;

  always @(posedge clk) begin
    if (ram_write) mem[ram_wr_address] <= ram_data_in;
    rd_pend <= ram_read;
    if (ram_read) rd_q <= mem[ram_rd_address];
    bus_junk <= {$urandom, $urandom};
  end

  // Junk stands in for a floating bus outside the valid read window.
  assign ram_data_out = rd_pend ? rd_q : bus_junk;

  // ---------------- reference model + compare ----------------
  logic [DATA_W-1:0] q [$];
  int                wr_n = 0;
  int                rd_n = 0;
  int                pops = 0;
  logic [DATA_W-1:0] last_pop = '0;

  always @(negedge clk) begin
    if (rst) begin
      check("s_ready_in_rst", 64'(s_ready), 64'd0);
      check("ram_write_in_rst", 64'(ram_write), 64'd0);
      check("ram_read_in_rst", 64'(ram_read), 64'd0);
      q.delete();
      wr_n = 0;
      rd_n = 0;
    end else begin
      check("count", 64'(count), 64'(q.size()));
      check("empty", 64'(empty), 64'(q.size() == 0));
      check("full_vs_s_ready", 64'(full), 64'(!s_ready));
      check("ram_write", 64'(ram_write), 64'(s_valid && s_ready));
      if (s_valid && s_ready) begin
        check("wr_address", 64'(ram_wr_address), 64'(wr_n % DEPTH));
        check("wr_data", ram_data_in, s_data);
        q.push_back(s_data);
        wr_n++;
      end
      if (ram_read) begin
        check("rd_address", 64'(ram_rd_address), 64'(rd_n % DEPTH));
        check("read_of_written_word", 64'(rd_n < wr_n), 64'd1);
        rd_n++;
      end
      if (m_valid) begin
        check("m_valid_has_word", 64'(q.size() != 0), 64'd1);
        if (m_ready && q.size() != 0) begin
          check("m_data_order", m_data, q[0]);
          last_pop = q.pop_front();
          pops++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push n words (base + i) with the current m_ready; bounded.
  task automatic push_words(input int n, input logic [63:0] base, input bit rand_valid, input bit rand_ready);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 70000) begin
      step();
      s_valid = rand_valid ? 1'($urandom % 2) : 1'b1;
      if (rand_ready) m_ready = 1'($urandom % 2);
      s_data = base + 64'(k);
      @(negedge clk);
      if (s_valid && s_ready) k++;
      guard++;
    end
    step();
    s_valid = 1'b0;
    check("push_words_done", 64'(k), 64'(n));
  endtask

  task automatic drain(input int n_from);
    int guard = 0;
    m_ready = 1'b1;
    while (pops < n_from && guard < 10000) begin
      step();
      guard++;
    end
    check("drain_done", 64'(pops), 64'(n_from));
  endtask

  initial begin
    int base;
    int k;
    int cyc;

    // ---- reset ----
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_ram_read", 64'(ram_read), 64'd0);
    check("rst_ram_write", 64'(ram_write), 64'd0);
    check("rst_wr_addr", 64'(ram_wr_address), 64'd0);
    check("rst_rd_addr", 64'(ram_rd_address), 64'd0);
    check("rst_data_in", ram_data_in, 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_s_ready", 64'(s_ready), 64'd1);

    // ---- single word latency ----
    step();
    s_valid = 1'b1;
    s_data  = 64'hA5A5_0000_0000_0001;
    m_ready = 1'b1;
    @(negedge clk);
    check("lat_write", 64'(ram_write), 64'd1);
    check("lat_wr_addr", 64'(ram_wr_address), 64'd0);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check("lat_read", 64'(ram_read), 64'd1);
    check("lat_rd_addr", 64'(ram_rd_address), 64'd0);
    check("lat_mv_c1", 64'(m_valid), 64'd0);
    step();
    @(negedge clk);
    check("lat_mv_c2", 64'(m_valid), 64'd0);
    step();
    @(negedge clk);
    check("lat_mv_c3", 64'(m_valid), 64'd1);
    check("lat_data", m_data, 64'hA5A5_0000_0000_0001);
    step();
    @(negedge clk);
    check("lat_empty_after", 64'(empty), 64'd1);

    // ---- fill to DEPTH+2 with consumer stalled ----
    m_ready = 1'b0;
    push_words(DEPTH + 2, 64'd0, 1'b0, 1'b0);
    repeat (3) step();
    @(negedge clk);
    check("fill_count", 64'(count), 64'd4098);
    check("fill_full", 64'(full), 64'd1);
    check("fill_s_ready", 64'(s_ready), 64'd0);
    check("fill_head", m_data, 64'd0);
    base = pops;
    drain(base + DEPTH + 2);
    check("fill_last_word", last_pop, 64'd4097);

    // ---- continuous 10000 words, one per cycle ----
    base = pops;
    k = 0;
    cyc = 0;
    m_ready = 1'b1;
    while ((pops - base) < 10000 && cyc < 12000) begin
      step();
      s_valid = (k < 10000);
      s_data  = 64'h3000_0000_0000_0000 | 64'(k);
      @(negedge clk);
      if (s_valid && s_ready) k++;
      cyc++;
    end
    step();
    s_valid = 1'b0;
    check("stream_all_out", 64'(pops - base), 64'd10000);
    check("stream_throughput", 64'(cyc <= 10005), 64'd1);
    check("stream_last_word", last_pop, 64'h3000_0000_0000_270F);

    // ---- random valid/ready, 20000 words ----
    base = pops;
    push_words(20000, 64'h7000_0000_0000_0000, 1'b1, 1'b1);
    drain(base + 20000);

    // ---- reset with words stored and a read in flight ----
    m_ready = 1'b0;
    push_words(100, 64'hC000_0000_0000_0000, 1'b0, 1'b0);
    step();
    m_ready = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!ram_read && cyc < 10) begin
      step();
      @(negedge clk);
      cyc++;
    end
    check("mid_read_seen", 64'(ram_read), 64'd1);
    step();
    rst = 1'b1;
    m_ready = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_m_valid", 64'(m_valid), 64'd0);
    check("mid_count", 64'(count), 64'd0);
    check("mid_empty", 64'(empty), 64'd1);
    check("mid_ram_read", 64'(ram_read), 64'd0);
    step();
    s_valid = 1'b1;
    s_data  = 64'h1234;
    step();
    s_valid = 1'b0;
    step();
    @(negedge clk);
    check("post_rst_mv_c2", 64'(m_valid), 64'd0);
    step();
    @(negedge clk);
    check("post_rst_mv_c3", 64'(m_valid), 64'd1);
    check("post_rst_data", m_data, 64'h1234);
    m_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("final_empty", 64'(empty), 64'd1);
    check("final_queue", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
